// File: rtl/pmem_line_responder.sv
// Line-granular physical memory responder with a fixed access latency.
// Accepts 128-bit line reads/writes and pulses pmem_resp on completion.
module pmem_line_responder #(
    parameter int DELAY      = 4,
    parameter int INDEX_BITS = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [15:0]  pmem_address,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [127:0] pmem_wdata,
    output logic [127:0] pmem_rdata,
    output logic         pmem_resp,
    output logic         busy,
    output logic         protocol_error
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                  state, state_next;
    logic [7:0]              cnt, cnt_next;
    logic                    accept;
    logic                    mismatch;
    logic [INDEX_BITS-1:0]   addr_idx;
    logic [INDEX_BITS-1:0]   idx;
    logic                    lat_read;
    logic                    lat_write;
    logic [127:0]            wdata_q;
    logic [127:0]            mem [2**INDEX_BITS];
    logic                    unused_addr;

    assign addr_idx    = pmem_address[INDEX_BITS+3:4];
    assign unused_addr = ^{pmem_address[15:INDEX_BITS+4], pmem_address[3:0]};
    assign busy        = (state == BUSY);

    // Any wiggle of the held request while busy is a violation
    assign mismatch = (state == BUSY) &&
                      ((addr_idx != idx) ||
                       (pmem_read != lat_read) ||
                       (pmem_write != lat_write));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        pmem_resp  = 1'b0;
        unique case (state)
            IDLE: begin
                if (pmem_read || pmem_write) begin
                    accept     = 1'b1;
                    cnt_next   = 8'(DELAY - 1);
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (cnt != 8'd0) begin
                    cnt_next = cnt - 8'd1;
                end else begin
                    pmem_resp  = 1'b1;
                    state_next = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx            <= '0;
            lat_read       <= 1'b0;
            lat_write      <= 1'b0;
            wdata_q        <= '0;
            pmem_rdata     <= '0;
            protocol_error <= 1'b0;
        end else begin
            if (accept) begin
                idx       <= addr_idx;
                lat_read  <= pmem_read;
                lat_write <= pmem_write;
                wdata_q   <= pmem_wdata;
                // Write wins when both are requested
                if (!pmem_write) begin
                    pmem_rdata <= mem[addr_idx];
                end
                if (pmem_read && pmem_write) begin
                    protocol_error <= 1'b1;
                end
            end
            if (mismatch) begin
                protocol_error <= 1'b1;
            end
        end
    end

    // Storage is deliberately unreset; commit happens on the resp edge
    always_ff @(posedge clk) begin
        if (pmem_resp && lat_write) begin
            mem[idx] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_pmem_line_responder.sv
// Directed bench for pmem_line_responder at DELAY 4, 1 and 7.
module tb_pmem_line_responder;

    logic         clk;
    logic         reset;
    logic [15:0]  addr;
    logic [127:0] wdata;
    logic [2:0]   rd;
    logic [2:0]   wr;
    logic [2:0]   resp;
    logic [2:0]   bsy;
    logic [2:0]   perr;
    logic [127:0] rdata [3];

    int n_chk  = 0;
    int n_fail = 0;

    pmem_line_responder #(.DELAY(4), .INDEX_BITS(8)) dut4 (
        .clk(clk), .reset(reset), .pmem_address(addr),
        .pmem_read(rd[0]), .pmem_write(wr[0]), .pmem_wdata(wdata),
        .pmem_rdata(rdata[0]), .pmem_resp(resp[0]), .busy(bsy[0]),
        .protocol_error(perr[0])
    );

    pmem_line_responder #(.DELAY(1), .INDEX_BITS(8)) dut1 (
        .clk(clk), .reset(reset), .pmem_address(addr),
        .pmem_read(rd[1]), .pmem_write(wr[1]), .pmem_wdata(wdata),
        .pmem_rdata(rdata[1]), .pmem_resp(resp[1]), .busy(bsy[1]),
        .protocol_error(perr[1])
    );

    pmem_line_responder #(.DELAY(7), .INDEX_BITS(8)) dut7 (
        .clk(clk), .reset(reset), .pmem_address(addr),
        .pmem_read(rd[2]), .pmem_write(wr[2]), .pmem_wdata(wdata),
        .pmem_rdata(rdata[2]), .pmem_resp(resp[2]), .busy(bsy[2]),
        .protocol_error(perr[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; request is high from cycle 0 and dropped in
    // the cycle after resp. Cycle i is observed at the i-th negedge.
    task automatic txn(input int sel, input logic [15:0] a,
                       input logic r, input logic w, input logic [127:0] wd,
                       output int lat, output int bc, output int rc,
                       output logic pe1, output logic [127:0] r1);
        lat = 0; bc = 0; rc = 0; pe1 = 1'b0; r1 = '0;
        addr = a; wdata = wd; rd[sel] = r; wr[sel] = w;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) begin
                pe1 = perr[sel];
                r1  = rdata[sel];
            end
            if (bsy[sel]) bc++;
            if (resp[sel]) begin
                rc++;
                if (lat == 0) lat = i;
            end else if (lat != 0) begin
                break;
            end
        end
        rd[sel] = 1'b0;
        wr[sel] = 1'b0;
    endtask

    task automatic rst_pulse();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    localparam logic [127:0] L1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] LA = {16{8'h5A}};
    localparam logic [127:0] LB = {16{8'hB7}};
    localparam logic [127:0] LAA = {16{8'hAA}};
    localparam logic [127:0] LC = {8{16'hC0DE}};
    localparam logic [127:0] LD = {4{32'hD00D_F00D}};
    localparam logic [127:0] LE = {4{32'hEEEE_1234}};

    initial begin
        int lat, bc, rc;
        logic pe1;
        logic [127:0] r1;

        reset = 1'b1;
        addr  = '0;
        wdata = '0;
        rd    = '0;
        wr    = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        chk("reset_resp",  128'(resp[0]), 128'd0);
        chk("reset_busy",  128'(bsy[0]),  128'd0);
        chk("reset_rdata", rdata[0],      128'd0);
        chk("reset_perr",  128'(perr[0]), 128'd0);

        // Write then read with DELAY=4, read issued back-to-back
        txn(0, 16'h1230, 1'b0, 1'b1, L1, lat, bc, rc, pe1, r1);
        chk("wr_lat", 128'(lat), 128'd4);
        chk("wr_busy_cycles", 128'(bc), 128'd4);
        chk("wr_resp_width", 128'(rc), 128'd1);
        chk("wr_rdata_untouched", rdata[0], 128'd0);
        txn(0, 16'h123A, 1'b1, 1'b0, '0, lat, bc, rc, pe1, r1);
        chk("rd_lat", 128'(lat), 128'd4);
        chk("rd_data_cycle1", r1, L1);
        chk("rd_data", rdata[0], L1);
        chk("rd_perr", 128'(perr[0]), 128'd0);

        // Latency sweep
        txn(1, 16'h0000, 1'b0, 1'b1, LA, lat, bc, rc, pe1, r1);
        chk("d1_lat", 128'(lat), 128'd1);
        chk("d1_busy_cycles", 128'(bc), 128'd1);
        chk("d1_resp_width", 128'(rc), 128'd1);
        txn(1, 16'h0000, 1'b1, 1'b0, '0, lat, bc, rc, pe1, r1);
        chk("d1_rd_data", rdata[1], LA);
        txn(2, 16'h0000, 1'b1, 1'b1, LB, lat, bc, rc, pe1, r1);
        chk("d7_lat", 128'(lat), 128'd7);
        chk("d7_busy_cycles", 128'(bc), 128'd7);
        chk("d7_resp_width", 128'(rc), 128'd1);

        // Aliasing on upper address bits
        txn(0, 16'h0010, 1'b0, 1'b1, LA, lat, bc, rc, pe1, r1);
        txn(0, 16'h1010, 1'b0, 1'b1, LB, lat, bc, rc, pe1, r1);
        txn(0, 16'h0010, 1'b1, 1'b0, '0, lat, bc, rc, pe1, r1);
        chk("alias_data", rdata[0], LB);
        chk("alias_perr", 128'(perr[0]), 128'd0);

        // Read and write together: write wins, flag raised
        txn(0, 16'h0040, 1'b1, 1'b1, LAA, lat, bc, rc, pe1, r1);
        chk("both_perr_cycle1", 128'(pe1), 128'd1);
        chk("both_lat", 128'(lat), 128'd4);
        chk("both_rdata_kept", rdata[0], LB);
        txn(0, 16'h0040, 1'b1, 1'b0, '0, lat, bc, rc, pe1, r1);
        chk("both_readback", rdata[0], LAA);
        chk("perr_sticky", 128'(perr[0]), 128'd1);
        rst_pulse();
        chk("perr_cleared", 128'(perr[0]), 128'd0);

        // Request dropped in BUSY cycle 2
        addr = 16'h0040; rd[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rd[0] = 1'b0;
        @(negedge clk);
        chk("drop_perr", 128'(perr[0]), 128'd1);
        chk("drop_no_early_resp", 128'(resp[0]), 128'd0);
        @(negedge clk);
        chk("drop_resp_c4", 128'(resp[0]), 128'd1);
        @(negedge clk);
        chk("drop_idle_c5", 128'(bsy[0]), 128'd0);
        chk("drop_rdata", rdata[0], LAA);
        rst_pulse();

        // Address changed in BUSY cycle 2: latched index still used
        addr = 16'h0040; wdata = LD; wr[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        addr = 16'h0050;
        @(negedge clk);
        chk("addr_chg_perr", 128'(perr[0]), 128'd1);
        @(negedge clk);
        chk("addr_chg_resp_c4", 128'(resp[0]), 128'd1);
        @(negedge clk);
        wr[0] = 1'b0;
        rst_pulse();
        txn(0, 16'h0040, 1'b1, 1'b0, '0, lat, bc, rc, pe1, r1);
        chk("addr_chg_commit", rdata[0], LD);

        // Reset mid-write must not commit
        txn(0, 16'h0080, 1'b0, 1'b1, LC, lat, bc, rc, pe1, r1);
        txn(0, 16'h0080, 1'b1, 1'b0, '0, lat, bc, rc, pe1, r1);
        chk("pre_rst_data", rdata[0], LC);
        addr = 16'h0080; wdata = LE; wr[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_mid_resp", 128'(resp[0]), 128'd0);
        chk("rst_mid_busy", 128'(bsy[0]), 128'd0);
        chk("rst_mid_rdata", rdata[0], 128'd0);
        wr[0] = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        txn(0, 16'h0080, 1'b1, 1'b0, '0, lat, bc, rc, pe1, r1);
        chk("post_rst_lat", 128'(lat), 128'd4);
        chk("post_rst_data", rdata[0], LC);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pmem_line_responder.md
# pmem_line_responder

Line-granular physical memory responder for the MP2 cache. It is the memory-side counterpart of the cache controller: it accepts 128-bit line read/write requests on the pmem interface, models a fixed access latency, and signals completion with a single-cycle `pmem_resp`. It is used as the backing store in the cache testbench and as a synthesizable memory stub in top-level integration.

## Interface
Parameters:
- `DELAY`, default 4: access latency in cycles; legal range 1 to 255.
- `INDEX_BITS`, default 8: line-index width; the array holds 2^INDEX_BITS lines of 128 bits.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `pmem_address`  in  16  byte address (`lc3b_word`); bits [3:0] are ignored, bits [INDEX_BITS+3:4] form the line index, and higher bits are ignored (aliasing).
- `pmem_read`  in  1  line read request.
- `pmem_write`  in  1  line write request.
- `pmem_wdata`  in  128  write line data.
- `pmem_rdata`  out  128  read line data.
- `pmem_resp`  out  1  completion pulse, one cycle wide.
- `busy`  out  1  high while a request is in flight.
- `protocol_error`  out  1  sticky protocol-violation flag.

## Operation
- FSM states are IDLE and BUSY. A down-counter `cnt` is 8 bits wide.
- In IDLE with `pmem_read | pmem_write` high, the request is accepted at the clock edge:
  - latch the op, index and `pmem_wdata`;
  - for a read, load `pmem_rdata` from `array[index]`;
  - load `cnt = DELAY-1`;
  - go to BUSY.
- In BUSY with `cnt != 0`, decrement `cnt`.
- `pmem_resp` is the combinational decode `state==BUSY && cnt==0`.
- At the edge that ends the resp cycle:
  - for a write, commit the latched wdata into `array[latched index]`;
  - go to IDLE.
- `busy` is high exactly when state is BUSY.
- `pmem_rdata` holds its last loaded value until the next accepted read. Writes never modify `pmem_rdata`.
- If both `pmem_read` and `pmem_write` are high at acceptance, the write wins and `protocol_error` is set.
- While in BUSY, `protocol_error` is set if any of the following differs from its latched value:
  - `pmem_address[INDEX_BITS+3:4]`;
  - `pmem_read`;
  - `pmem_write`.
- A dropped request during BUSY is a violation, but the transaction still completes with the latched values. There is no abort.
- `protocol_error` clears only on reset.
- The array has no reset and is not initialized. The contents of never-written lines are unspecified, and the bench must write before it checks.

## Timing
- Reset values: state IDLE, `cnt` 0, `pmem_resp` 0, `busy` 0, `pmem_rdata` 0, `protocol_error` 0.
- Cycle numbering:
  - the request is high in cycle 0 while in IDLE and is accepted at the end of cycle 0;
  - `busy` is high in cycles 1 through DELAY;
  - `pmem_resp` is high in cycle DELAY only.
- With DELAY=1, resp comes in cycle 1.
- Read data is valid no later than the resp cycle; in fact it is valid from cycle 1.
- The requester holds the request through the resp cycle and drops it in the cycle after.
- The block is back in IDLE in cycle DELAY+1. A request high in that cycle is accepted, so back-to-back transactions are spaced DELAY+1 cycles apart.
- A read accepted in cycle DELAY+1 to the line written by the previous transaction returns the new data; the commit precedes the read.
- Reset asserted mid-transaction:
  - state returns to IDLE immediately (asynchronously) and `pmem_resp` drops the same cycle;
  - a pending write is not committed;
  - array contents are otherwise preserved.
- After reset deasserts, a held request is accepted at the next edge.

## Test plan
- Write then read, DELAY=4: write line `0x0123_4567_89AB_CDEF_FEDC_BA98_7654_3210` at address `0x1230`, then read `0x123A`. Required: resp in cycle 4 of each transaction, and `pmem_rdata` equals the written line.
- Latency sweep with DELAY=1 and DELAY=7: measure acceptance-to-resp. Required: exactly 1 and 7 cycles, `busy` high for exactly DELAY cycles, and resp exactly one cycle wide.
- Aliasing, INDEX_BITS=8: write A to `0x0010` and B to `0x1010`, then read `0x0010`. Required: B, and `protocol_error` stays 0.
- Both `pmem_read` and `pmem_write` asserted with wdata `0xAA..AA` at `0x0040`. Required: `protocol_error`=1 from cycle 1, and a later read of `0x0040` returns `0xAA..AA`.
- Request dropped, or address changed, in BUSY cycle 2. Required: `protocol_error`=1, and resp still arrives in cycle DELAY.
- Reset in cycle 2 of a write to `0x0080` that was previously holding C. Required: `pmem_resp`, `busy` and `pmem_rdata` all 0 immediately; after reset, a read of `0x0080` returns C.
